// File: rtl/push_button_gen_pkg.sv
// push_button_gen_pkg: command kinds, FSM states and default phase lengths.
package push_button_gen_pkg;
  typedef enum logic [1:0] {K_SHORT, K_LONG, K_DOUBLE, K_IR} kind_t;
  typedef enum logic [2:0] {S_IDLE, S_PRESS, S_GAP, S_PRESS2, S_IR, S_REL} state_t;
  localparam int DEF_CNT_W = 13;
  localparam int DEF_SHORT_CYC = 100;
  localparam int DEF_LONG_CYC = 5400;
  localparam int DEF_GAP_CYC = 500;
  localparam int DEF_REL_CYC = 500;
  localparam int DEF_IR_CYC = 200;
endpackage

// File: rtl/push_button_gen_phase_timer.sv
// phase_timer: loadable down counter; o_expired is high once the count reaches 0.
module phase_timer #(
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_expired
);
  logic [CNT_W-1:0] r_cnt;
  logic r_exp;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_exp <= 1'b1;
    end else if (i_load) begin
      r_cnt <= i_val;
      r_exp <= i_val == '0;
    end else if (!r_exp) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_exp <= r_cnt == CNT_W'(1);
    end
  end
  assign o_expired = r_exp;
endmodule

// File: rtl/push_button_gen.sv
// push_button_gen: drives cycle-exact button / IR waveforms from handshaked commands.
// Define PUSH_BUTTON_GEN_BOUNCE_EN to add LFSR contact bounce at the start of button phases.
import push_button_gen_pkg::*;
module push_button_gen #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int SHORT_CYC = DEF_SHORT_CYC,
  parameter int LONG_CYC = DEF_LONG_CYC,
  parameter int GAP_CYC = DEF_GAP_CYC,
  parameter int REL_CYC = DEF_REL_CYC,
  parameter int IR_CYC = DEF_IR_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_kind,
  output logic       cmd_ready,
  output logic       push_button,
  output logic       infravermelho,
  output logic       busy,
  output logic       done
);
  localparam int MAX_CYC = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] SHORT_M1 = CNT_W'(SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] REL_M1 = CNT_W'(REL_CYC - 1);
  localparam logic [CNT_W-1:0] IR_M1 = CNT_W'(IR_CYC - 1);
  if (SHORT_CYC < 1 || SHORT_CYC > MAX_CYC || LONG_CYC < 1 || LONG_CYC > MAX_CYC ||
      GAP_CYC < 1 || GAP_CYC > MAX_CYC || REL_CYC < 1 || REL_CYC > MAX_CYC ||
      IR_CYC < 1 || IR_CYC > MAX_CYC) begin : g_bad_range
    $error("push_button_gen: cycle parameter outside 1..2**CNT_W-1");
  end
  state_t r_state, w_next;
  kind_t r_kind, w_kind;
  logic r_pb, r_ir, r_busy, r_done, r_ready;
  logic w_accept, w_load, w_exp, w_nom, w_pb;
  logic [CNT_W-1:0] w_val;
  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .rst(rst), .i_load(w_load), .i_val(w_val), .o_expired(w_exp)
  );
  always_comb begin
    w_accept = cmd_valid && r_ready;
    w_kind = (r_state == S_IDLE) ? kind_t'(cmd_kind) : r_kind;
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = !w_accept ? S_IDLE : (w_kind == K_IR) ? S_IR : S_PRESS;
      S_PRESS: if (w_exp) w_next = (r_kind == K_DOUBLE) ? S_GAP : S_REL;
      S_GAP: if (w_exp) w_next = S_PRESS2;
      S_PRESS2, S_IR: if (w_exp) w_next = S_REL;
      S_REL: if (w_exp) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // every phase entry is a state change, so that is when the timer reloads
    w_load = w_next != r_state;
    w_val = (w_next == S_PRESS) ? ((w_kind == K_LONG) ? LONG_M1 : SHORT_M1) :
            (w_next == S_GAP) ? GAP_M1 :
            (w_next == S_PRESS2) ? SHORT_M1 :
            (w_next == S_IR) ? IR_M1 :
            (w_next == S_REL) ? REL_M1 : '0;
    w_nom = w_next inside {S_PRESS, S_PRESS2};
  end
`ifdef PUSH_BUTTON_GEN_BOUNCE_EN
  if (SHORT_CYC < 9 || GAP_CYC < 9) begin : g_bad_bounce
    $error("push_button_gen: bounce needs SHORT_CYC and GAP_CYC >= 9");
  end
  logic [7:0] r_lfsr, w_lfsr;
  logic [2:0] r_bnc;
  always_comb begin
    w_lfsr = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    w_pb = ((w_next inside {S_PRESS, S_PRESS2, S_GAP, S_REL}) && (w_load || r_bnc != 3'd0)) ?
           w_lfsr[0] : w_nom;
  end
  // r_bnc counts the bounce cycles still owed after the current one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 8'hA5;
      r_bnc <= 3'd0;
    end else begin
      r_lfsr <= w_lfsr;
      r_bnc <= w_load ? 3'd7 : (r_bnc != 3'd0) ? r_bnc - 3'd1 : 3'd0;
    end
  end
`else
  assign w_pb = w_nom;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_kind <= K_SHORT;
      r_pb <= 1'b0;
      r_ir <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_accept) r_kind <= w_kind;
      r_pb <= w_pb;
      r_ir <= w_next == S_IR;
      r_busy <= w_next != S_IDLE;
      r_ready <= w_next == S_IDLE;
      r_done <= (r_state == S_REL) && (w_next == S_IDLE);
    end
  end
  assign cmd_ready = r_ready;
  assign push_button = r_pb;
  assign infravermelho = r_ir;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_push_button_gen.sv
// tb_push_button_gen: vector table + segment scoreboard for push_button_gen.
module tb_push_button_gen;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [1:0] cmd_kind = 2'd0;
  logic cmd_ready, push_button, infravermelho, busy, done;
  always #5 clk = ~clk;
  push_button_gen dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_kind(cmd_kind), .cmd_ready(cmd_ready),
    .push_button(push_button), .infravermelho(infravermelho), .busy(busy), .done(done)
  );
  typedef struct {logic pb; logic ir; int len;} seg_t;
  typedef struct {logic [1:0] kind; int total;} vec_t;
  seg_t sb[$];
  vec_t vecs[5];
  int n_vec = 0, n_err = 0;
  logic cur_pb, cur_ir;
  int run = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  function automatic void expect_cmd(input logic [1:0] k);
    case (k)
      2'd0: sb.push_back('{1'b1, 1'b0, 100});
      2'd1: sb.push_back('{1'b1, 1'b0, 5400});
      2'd2: begin
        sb.push_back('{1'b1, 1'b0, 100});
        sb.push_back('{1'b0, 1'b0, 500});
        sb.push_back('{1'b1, 1'b0, 100});
      end
      default: sb.push_back('{1'b0, 1'b1, 200});
    endcase
    sb.push_back('{1'b0, 1'b0, 500});
  endfunction
  task automatic close_seg();
    seg_t e;
    if (sb.size() == 0) check("unexpected_segment", run, 0);
    else begin
      e = sb.pop_front();
      check("segment_level", {cur_pb, cur_ir}, {e.pb, e.ir});
      check("segment_length", run, e.len);
    end
  endtask
`ifndef PUSH_BUTTON_GEN_BOUNCE_EN
  // run-length monitor: each busy stretch of constant (push_button, infravermelho) is one segment
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
      sb.delete();
    end else begin
      if (push_button && infravermelho) check("lines_exclusive", 1, 0);
      if (busy === cmd_ready) check("ready_vs_busy", cmd_ready, !busy);
      if (busy && run > 0 && push_button === cur_pb && infravermelho === cur_ir) run++;
      else begin
        if (run > 0) close_seg();
        cur_pb = push_button;
        cur_ir = infravermelho;
        run = busy ? 1 : 0;
      end
    end
  end
`endif
  task automatic send(input logic [1:0] k, input bit hold);
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 8000) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) check("ready_timeout", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_kind = k;
    expect_cmd(k);
    @(posedge clk);
    #1 if (!hold) cmd_valid = 1'b0;
    @(negedge clk);
    check("first_cycle", {push_button, infravermelho, busy, cmd_ready},
          (k == 2'd3) ? 4'b0110 : 4'b1010);
  endtask
  task automatic wait_done(input int total);
    int t = 1;
    while (!done && t < 8000) begin
      @(negedge clk);
      t++;
    end
    check("done_time", t, total);
  endtask
`ifdef PUSH_BUTTON_GEN_BOUNCE_EN
  logic [7:0] m_lfsr;
  always @(posedge clk) m_lfsr <= rst ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
  initial begin
    vecs = '{'{2'd0, 601}, '{2'd1, 5901}, '{2'd2, 1201}, '{2'd3, 701}, '{2'd0, 601}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {push_button, infravermelho, busy, done, cmd_ready}, 5'b00001);
    rst = 1'b0;
`ifndef PUSH_BUTTON_GEN_BOUNCE_EN
    foreach (vecs[i]) begin
      send(vecs[i].kind, 1'b0);
      wait_done(vecs[i].total);
      @(negedge clk);
      check("done_width", done, 0);
    end
    // IR with valid held through busy: the next SHORT is taken on the done cycle
    send(2'd3, 1'b1);
    cmd_kind = 2'd0;
    expect_cmd(2'd0);
    wait_done(701);
    check("ready_on_done", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_accept", {busy, push_button, done}, 3'b110);
    wait_done(601);
    // reset during cycle 50 of a LONG press
    send(2'd1, 1'b0);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_long", {push_button, infravermelho, busy, done, cmd_ready}, 5'b00001);
    @(posedge clk);
    #1 rst = 1'b0;
    send(2'd0, 1'b0);
    wait_done(601);
    @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
`else
    begin
      int t;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_kind = 2'd0;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        check("bounce_press", push_button, (i < 8) ? m_lfsr[0] : 1'b1);
      end
      t = 100;
      do begin
        @(negedge clk);
        t++;
      end while (!done && t < 1000);
      check("bounce_done_time", t, 601);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
